msk_g4mul_rnd_gen: RTL and testbench
====================================

Name: msk_g4mul_rnd_gen

Overview:
- Randomness source sitting directly upstream of the HPC1 G(4) masked multiplier; drives its refresh randomness (rnd_ref) and multiplication randomness (rnd_mul) buses.
- 64-bit Fibonacci LFSR, unrolled to produce W fresh bits per enabled cycle.
- Seeded over a 32-bit valid/ready port; warm-up phase after every (re)seed; rnd_valid qualifies output freshness.

Parameters:
- d, 2, number of shares (informational; sizes defaults below).
- N_REF, 1, random bits per refresh gadget (multiplier consumes 2*N_REF).
- N_MUL, 1, random bits per DOM multiplication lane (multiplier consumes 2*N_MUL).
- WARMUP, 8, enabled cycles discarded after seeding, 1..255.
- Derived: W = 2*N_REF + 2*N_MUL; W <= 64 is required (elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- seed_data  in  32  seed word.
- seed_valid  in  1  seed word offered.
- seed_ready  out  1  seed word accepted when seed_valid && seed_ready.
- en  in  1  advance request from consumer (one fresh batch per cycle).
- rnd_ref  out  2*N_REF  refresh randomness = batch bits [2*N_REF-1:0].
- rnd_mul  out  2*N_MUL  multiplication randomness = batch bits [W-1:2*N_REF].
- rnd_valid  out  1  outputs hold a fresh batch produced under RUN.

Behaviour:
- LFSR step: fb = s[63]^s[62]^s[60]^s[59]; s <= {s[62:0], fb}.
- One advance = W consecutive steps in one cycle. Batch bit i = feedback bit of the (i+1)-th step.
- rnd_ref/rnd_mul are registered and load the batch on every advance; otherwise they hold.
- Reset (async, any state): s=0, rnd_ref=0, rnd_mul=0, rnd_valid=0, warm counter=0, state=IDLE.
- FSM:
  - IDLE: seed_ready=1, rnd_valid=0. Handshake loads s[63:32] <= seed_data, then -> LOAD_LO. en is ignored.
  - LOAD_LO: seed_ready=1, rnd_valid=0. Handshake loads s[31:0] <= seed_data. If the resulting 64-bit state is all-zero, force s=64'h1. Clear warm counter, then -> WARM. en is ignored.
  - WARM: seed_ready=0, rnd_valid=0. Advances every cycle regardless of en; outputs update but stay invalid. After WARMUP advances -> RUN.
  - RUN: seed_ready=1. en=1 advances and sets rnd_valid=1 on the next cycle. en=0 leaves outputs holding their last value and keeps rnd_valid=1.
- Reseed in RUN: a seed handshake loads s[63:32] and goes -> LOAD_LO. No advance occurs that cycle, and rnd_valid=0 from the next cycle.
- Simultaneous en and seed handshake in RUN: the seed wins; no advance, outputs hold.
- rnd_valid only rises on the first RUN advance; it is never high in IDLE, LOAD_LO or WARM.
- Latency: en sampled in cycle t gives its batch on the outputs in cycle t+1.
- Warm counter saturates at WARMUP; no wrap.
- Consumer alignment: each enabled cycle yields a disjoint fresh batch. The multiplier consumes rnd_mul 1+ref_rndlat cycles after rnd_ref by pipelining on its side; this block adds no skew.

Test Plan:
- Reset mid-WARM (assert rst 1 cycle) -> rnd_valid=0, seed_ready=1, outputs 0, state IDLE, next seed word accepted as high word.
- d=2 (W=4), seed 0x00000000,0x00000000 -> state forced to 1. After 8 WARM cycles s=1<<32, rnd_valid=0. The first 6 RUN advances output rnd_ref=2'b00, rnd_mul=2'b00. The 7th advance outputs rnd_ref=2'b00, rnd_mul=2'b10.
- Seed 0xDEADBEEF,0x01234567 twice from reset -> bit-identical output sequences; compare 100 batches against a C/Python LFSR model.
- RUN with en toggling 1,0,0,1 -> outputs change only on cycles following en=1; rnd_valid stays 1 throughout.
- Reseed in RUN with en=1 on the same cycle -> no advance that cycle, rnd_valid=0 next cycle, seed_ready=0 during WARM, rnd_valid=1 again exactly WARMUP+1 advances after the LOAD_LO handshake.
- Seed handshakes with seed_valid high and backpressure in WARM -> word is not consumed until RUN; first accepted word goes to s[63:32].

Source files
------------

// File: rtl/msk_g4mul_rnd_gen.sv
// Seeded 64-bit Fibonacci LFSR feeding the HPC1 G(4) masked multiplier.
// Produces W = 2*N_REF + 2*N_MUL fresh bits per advance after a warm-up phase.
module msk_g4mul_rnd_gen #(
    parameter int unsigned d      = 2,
    parameter int unsigned N_REF  = 1,
    parameter int unsigned N_MUL  = 1,
    parameter int unsigned WARMUP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          seed_data,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic                 en,
    output logic [2*N_REF-1:0]   rnd_ref,
    output logic [2*N_MUL-1:0]   rnd_mul,
    output logic                 rnd_valid
);

    localparam int unsigned W = 2 * N_REF + 2 * N_MUL;
    localparam logic [7:0] WarmLast = 8'(WARMUP - 1);

    if (W > 64) begin : g_width_check
        $error("msk_g4mul_rnd_gen: W = 2*N_REF + 2*N_MUL must not exceed 64");
    end
    if (WARMUP < 1 || WARMUP > 255) begin : g_warmup_check
        $error("msk_g4mul_rnd_gen: WARMUP must be in 1..255");
    end
    if (d < 2) begin : g_share_check
        $error("msk_g4mul_rnd_gen: d must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StLoadLo, StWarm, StRun} state_e;

    state_e               state_q;
    logic [63:0]          s_q;
    logic [7:0]           cnt_q;
    logic [2*N_REF-1:0]   rnd_ref_q;
    logic [2*N_MUL-1:0]   rnd_mul_q;
    logic                 rnd_valid_q;

    logic [63:0]          s_adv;
    logic [W-1:0]         batch;
    logic                 fb;
    logic                 seed_hs;
    logic [63:0]          lo_seed;

    // W unrolled steps; batch bit i is the feedback of step i+1.
    always_comb begin
        s_adv = s_q;
        batch = '0;
        fb    = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            fb       = s_adv[63] ^ s_adv[62] ^ s_adv[60] ^ s_adv[59];
            batch[i] = fb;
            s_adv    = {s_adv[62:0], fb};
        end
    end

    assign seed_ready = (state_q != StWarm);
    assign seed_hs    = seed_valid && seed_ready;
    assign lo_seed    = {s_q[63:32], seed_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            s_q         <= '0;
            cnt_q       <= '0;
            rnd_ref_q   <= '0;
            rnd_mul_q   <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seed_hs) begin
                        s_q[63:32] <= seed_data;
                        state_q    <= StLoadLo;
                    end
                end
                StLoadLo: begin
                    if (seed_hs) begin
                        // The all-zero state is a fixed point of the LFSR.
                        s_q     <= (lo_seed == 64'd0) ? 64'd1 : lo_seed;
                        cnt_q   <= '0;
                        state_q <= StWarm;
                    end
                end
                StWarm: begin
                    s_q       <= s_adv;
                    rnd_ref_q <= batch[2*N_REF-1:0];
                    rnd_mul_q <= batch[W-1:2*N_REF];
                    if (cnt_q == WarmLast) begin
                        cnt_q   <= WarmLast + 8'd1;
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StRun: begin
                    // A seed handshake takes priority over an advance request.
                    if (seed_hs) begin
                        s_q[63:32]  <= seed_data;
                        rnd_valid_q <= 1'b0;
                        state_q     <= StLoadLo;
                    end else if (en) begin
                        s_q         <= s_adv;
                        rnd_ref_q   <= batch[2*N_REF-1:0];
                        rnd_mul_q   <= batch[W-1:2*N_REF];
                        rnd_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rnd_ref   = rnd_ref_q;
    assign rnd_mul   = rnd_mul_q;
    assign rnd_valid = rnd_valid_q;

endmodule

// File: tb/tb_msk_g4mul_rnd_gen.sv
// Self-checking bench for msk_g4mul_rnd_gen against a bit-stream reference model.
module tb_msk_g4mul_rnd_gen;

    localparam int unsigned NR = 1;
    localparam int unsigned NM = 1;
    localparam int unsigned WU = 8;
    localparam int unsigned W  = 2 * NR + 2 * NM;

    localparam int PH_IDLE = 0;
    localparam int PH_LO   = 1;
    localparam int PH_WARM = 2;
    localparam int PH_RUN  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   seed_data = '0;
    logic          seed_valid = 1'b0;
    logic          seed_ready;
    logic          en = 1'b0;
    logic [2*NR-1:0] rnd_ref;
    logic [2*NM-1:0] rnd_mul;
    logic          rnd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_phase;
    logic [63:0]   m_s;
    logic [2*NR-1:0] m_ref;
    logic [2*NM-1:0] m_mul;
    logic          m_valid;
    int            m_wcnt;

    logic [2*NR-1:0] rec_ref [100];
    logic [2*NM-1:0] rec_mul [100];

    msk_g4mul_rnd_gen #(
        .d      (2),
        .N_REF  (NR),
        .N_MUL  (NM),
        .WARMUP (WU)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_data  (seed_data),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .en         (en),
        .rnd_ref    (rnd_ref),
        .rnd_mul    (rnd_mul),
        .rnd_valid  (rnd_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_s     = '0;
        m_ref   = '0;
        m_mul   = '0;
        m_valid = 1'b0;
        m_wcnt  = 0;
    endtask

    // Pull W successive bits from the LFSR output stream into one batch.
    task automatic model_advance();
        logic [W-1:0] b;
        logic         bit_out;
        b = '0;
        for (int i = 0; i < int'(W); i++) begin
            bit_out = m_s[63] ^ m_s[62] ^ m_s[60] ^ m_s[59];
            b[i]    = bit_out;
            m_s     = {m_s[62:0], bit_out};
        end
        m_ref = b[2*NR-1:0];
        m_mul = b[W-1:2*NR];
    endtask

    task automatic model_edge(input logic e, input logic sv, input logic [31:0] sd);
        case (m_phase)
            PH_IDLE: if (sv) begin
                m_s[63:32] = sd;
                m_phase    = PH_LO;
            end
            PH_LO: if (sv) begin
                m_s[31:0] = sd;
                if (m_s == 64'd0) m_s = 64'd1;
                m_wcnt  = 0;
                m_phase = PH_WARM;
            end
            PH_WARM: begin
                model_advance();
                m_wcnt++;
                if (m_wcnt == int'(WU)) m_phase = PH_RUN;
            end
            default: begin
                if (sv) begin
                    m_s[63:32] = sd;
                    m_valid    = 1'b0;
                    m_phase    = PH_LO;
                end else if (e) begin
                    model_advance();
                    m_valid = 1'b1;
                end
            end
        endcase
    endtask

    task automatic tick(input logic e, input logic sv, input logic [31:0] sd);
        en         = e;
        seed_valid = sv;
        seed_data  = sd;
        model_edge(e, sv, sd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b0;
        seed_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick(0, 1, 32'h1234_5678);
        tick(0, 1, 32'h9abc_def0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        rst = 1'b1;
        model_reset();
        #2;
        n_checks++;
        if (rnd_ref !== 2'b00 || rnd_mul !== 2'b00 || rnd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ref=%b mul=%b valid=%b, want 00 00 0",
                     rnd_ref, rnd_mul, rnd_valid);
        end
        n_checks++;
        if (seed_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_seed_ready: got %b, want 1", seed_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(0, 1, 32'hcafe_f00d);
        tick(0, 1, 32'h0bad_beef);
        for (int i = 0; i < int'(WU) + 10; i++) begin
            tick(1, 0, 0);
            n_checks++;
            if (rnd_ref !== m_ref || rnd_mul !== m_mul || rnd_valid !== m_valid) begin
                n_fail++;
                $display("FAIL reset_reseed_seq[%0d]: got %b/%b/%b, want %b/%b/%b", i,
                         rnd_ref, rnd_mul, rnd_valid, m_ref, m_mul, m_valid);
            end
        end
    endtask

    task automatic test_zero_seed();
        do_reset();
        tick(0, 1, 32'h0);
        tick(0, 1, 32'h0);
        n_checks++;
        if (seed_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_warm_ready: got %b, want 0", seed_ready);
        end
        for (int i = 0; i < int'(WU); i++) begin
            tick(0, 0, 0);
            n_checks++;
            if (rnd_valid !== 1'b0 || rnd_ref !== 2'b00 || rnd_mul !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_warm[%0d]: got %b/%b/%b, want 00/00/0", i,
                         rnd_ref, rnd_mul, rnd_valid);
            end
        end
        n_checks++;
        if (seed_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_run_ready: got %b, want 1", seed_ready);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0);
            n_checks++;
            if (rnd_ref !== 2'b00 || rnd_mul !== 2'b00 || rnd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_run[%0d]: got %b/%b/%b, want 00/00/1", i,
                         rnd_ref, rnd_mul, rnd_valid);
            end
        end
        tick(1, 0, 0);
        n_checks++;
        if (rnd_ref !== 2'b00 || rnd_mul !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_run_7th: got ref=%b mul=%b, want 00 10", rnd_ref, rnd_mul);
        end
    endtask

    task automatic test_repeat_seed();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            tick(0, 1, 32'hdead_beef);
            tick(0, 1, 32'h0123_4567);
            for (int i = 0; i < int'(WU); i++) tick(0, 0, 0);
            for (int i = 0; i < 100; i++) begin
                tick(1, 0, 0);
                n_checks++;
                if (rnd_ref !== m_ref || rnd_mul !== m_mul || rnd_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL repeat_model[%0d][%0d]: got %b/%b/%b, want %b/%b/1",
                             pass, i, rnd_ref, rnd_mul, rnd_valid, m_ref, m_mul);
                end
                if (pass == 0) begin
                    rec_ref[i] = rnd_ref;
                    rec_mul[i] = rnd_mul;
                end else begin
                    n_checks++;
                    if (rnd_ref !== rec_ref[i] || rnd_mul !== rec_mul[i]) begin
                        n_fail++;
                        $display("FAIL repeat_identical[%0d]: got %b/%b, want %b/%b", i,
                                 rnd_ref, rnd_mul, rec_ref[i], rec_mul[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_en_toggle();
        logic [3:0] pat;
        logic       e;
        logic [2*NR-1:0] pr;
        logic [2*NM-1:0] pm;
        pat = 4'b1001;
        for (int i = 0; i < 24; i++) begin
            e  = (i < 4) ? pat[3-i] : 1'($urandom_range(1, 0));
            pr = m_ref;
            pm = m_mul;
            tick(e, 0, 0);
            n_checks++;
            if (rnd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL en_toggle_valid[%0d]: got %b, want 1", i, rnd_valid);
            end
            n_checks++;
            if (rnd_ref !== m_ref || rnd_mul !== m_mul) begin
                n_fail++;
                $display("FAIL en_toggle_out[%0d]: got %b/%b, want %b/%b", i,
                         rnd_ref, rnd_mul, m_ref, m_mul);
            end
            if (!e) begin
                n_checks++;
                if (rnd_ref !== pr || rnd_mul !== pm) begin
                    n_fail++;
                    $display("FAIL en_toggle_hold[%0d]: got %b/%b, want %b/%b", i,
                             rnd_ref, rnd_mul, pr, pm);
                end
            end
        end
    endtask

    task automatic test_reseed();
        logic [2*NR-1:0] pr;
        logic [2*NM-1:0] pm;
        int              k;
        pr = m_ref;
        pm = m_mul;
        tick(1, 1, 32'h5555_aaaa);
        n_checks++;
        if (rnd_ref !== pr || rnd_mul !== pm || rnd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reseed_hold: got %b/%b/%b, want %b/%b/0",
                     rnd_ref, rnd_mul, rnd_valid, pr, pm);
        end
        tick(1, 1, 32'h1357_9bdf);
        k = 0;
        while (rnd_valid !== 1'b1 && k < 40) begin
            n_checks++;
            if ((k < int'(WU)) && seed_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reseed_warm_ready[%0d]: got %b, want 0", k, seed_ready);
            end
            tick(1, 0, 0);
            k++;
        end
        n_checks++;
        if (k != int'(WU) + 1) begin
            n_fail++;
            $display("FAIL reseed_latency: got %0d advances, want %0d", k, WU + 1);
        end
        n_checks++;
        if (rnd_ref !== m_ref || rnd_mul !== m_mul) begin
            n_fail++;
            $display("FAIL reseed_out: got %b/%b, want %b/%b", rnd_ref, rnd_mul, m_ref, m_mul);
        end
    endtask

    task automatic test_backpressure();
        tick(0, 1, 32'h0f0f_0f0f);
        tick(0, 1, 32'hf0f0_f0f0);
        for (int i = 0; i < int'(WU); i++) begin
            tick(0, 1, 32'h7777_1111);
            n_checks++;
            if (rnd_valid !== 1'b0 || rnd_ref !== m_ref || rnd_mul !== m_mul) begin
                n_fail++;
                $display("FAIL bp_warm[%0d]: got %b/%b/%b, want %b/%b/0", i,
                         rnd_ref, rnd_mul, rnd_valid, m_ref, m_mul);
            end
            if (i < int'(WU) - 1) begin
                n_checks++;
                if (seed_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready[%0d]: got %b, want 0", i, seed_ready);
                end
            end
        end
        tick(1, 1, 32'h7777_1111);
        tick(1, 1, 32'h2222_8888);
        for (int i = 0; i < int'(WU) + 20; i++) begin
            tick(1, 0, 0);
            n_checks++;
            if (rnd_ref !== m_ref || rnd_mul !== m_mul || rnd_valid !== m_valid) begin
                n_fail++;
                $display("FAIL bp_seq[%0d]: got %b/%b/%b, want %b/%b/%b", i,
                         rnd_ref, rnd_mul, rnd_valid, m_ref, m_mul, m_valid);
            end
        end
    endtask

    task automatic test_random();
        logic e;
        logic sv;
        for (int i = 0; i < 400; i++) begin
            e  = 1'($urandom_range(1, 0));
            sv = ($urandom_range(15, 0) == 0);
            tick(e, sv, $urandom);
            n_checks++;
            if (rnd_ref !== m_ref || rnd_mul !== m_mul || rnd_valid !== m_valid ||
                seed_ready !== (m_phase != PH_WARM)) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%b/%b/%b, want %b/%b/%b/%b", i,
                         rnd_ref, rnd_mul, rnd_valid, seed_ready,
                         m_ref, m_mul, m_valid, (m_phase != PH_WARM));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_seed();
        test_repeat_seed();
        test_en_toggle();
        test_reseed();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
